// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the command-path sequencer: state codes (also the
// debug probe value), release-step error code and default stage timeout.
package cmd_seq_pkg;

  typedef enum logic [7:0] {
    IDLE = 8'h08,
    ARM  = 8'h03,
    RUN  = 8'h09,
    REL  = 8'h0A,
    DONE = 8'h0B,
    ERR  = 8'h0F
  } state_t;

  localparam int          IDX_W         = 3;
  localparam logic [3:0]  ERR_STAGE_REL = 4'hF;
  localparam int unsigned TIMEOUT_DEF   = 32'h0000_FFFF;

  // A stall in the release step is reported with its own code, not a stage index.
  function automatic logic [3:0] err_code(input state_t st, input logic [IDX_W-1:0] idx);
    return (st == REL) ? ERR_STAGE_REL : {1'b0, idx};
  endfunction

endpackage

// File: rtl/cmd_seq_if.sv
// Command handshake bundle between the receive-path stages/console (master)
// and the sequencer (slave).
interface cmd_seq_if #(
  parameter int NSTAGE = 3
);
  logic              ready;
  logic              trig;
  logic [NSTAGE-1:0] fd;
  logic [NSTAGE-1:0] fs;
  logic              ack_rx;
  logic              busy;
  logic              err;
  logic [3:0]        err_stage;
  logic              err_clr;
  logic [15:0]       cnt_pkt;
  logic [7:0]        so;

  modport master (
    output ready, trig, fd, err_clr,
    input  fs, ack_rx, busy, err, err_stage, cnt_pkt, so
  );

  modport slave (
    input  ready, trig, fd, err_clr,
    output fs, ack_rx, busy, err, err_stage, cnt_pkt, so
  );

endinterface

// File: rtl/cmd_seq_timer.sv
// seq_timer: per-stage stall counter. Counts while enabled, restarts on clear,
// and flags expiry in the cycle whose increment would reach TIMEOUT.
module seq_timer #(
  parameter int          TO_W    = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  // Gated by clr so a stage completing on its last allowed cycle is not an error.
  assign expire = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: walks NSTAGE fs/fd handshake stages per pending UDP packet and
// releases the MAC buffer after REL_STAGE. Stage timeout under CMD_SEQ_TIMEOUT_EN.
module cmd_seq
  import cmd_seq_pkg::*;
#(
  parameter int          NSTAGE    = 3,
  parameter int          REL_STAGE = 0,
  parameter int          TO_W      = 16,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input logic       sys_clk,
  input logic       rst,
  cmd_seq_if.slave  bus
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [NSTAGE-1:0] fs_q;
  logic              ack_q;
  logic              busy_q;
  logic              err_q;
  logic [3:0]        err_stage_q;
  logic [15:0]       cnt_pkt_q;

  logic stage_done;
  logic rel_done;
  logic tmo;

  function automatic logic [NSTAGE-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NSTAGE-1:0] v;
    v = '0;
    for (int k = 0; k < NSTAGE; k++)
      if (int'(i) == k) v[k] = 1'b1;
    return v;
  endfunction

  // fs_q is the one-hot of idx while in RUN, so it doubles as the fd mask.
  assign stage_done = (state == RUN) && |(bus.fd & fs_q);
  assign rel_done   = (state == REL) && !bus.trig;

`ifdef CMD_SEQ_TIMEOUT_EN
  logic tmr_en;
  logic tmr_clr;

  assign tmr_en  = (state == RUN) || (state == REL);
  assign tmr_clr = !tmr_en || stage_done || rel_done;

  seq_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expire  (tmo)
  );
`else
  localparam int unsigned unused_to_cfg = TIMEOUT + 32'(TO_W);
  logic unused_err_clr;

  assign unused_err_clr = bus.err_clr;
  assign tmo            = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      fs_q        <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
      cnt_pkt_q   <= '0;
    end else begin
`ifdef CMD_SEQ_TIMEOUT_EN
      if (tmo) begin
        err_q       <= 1'b1;
        err_stage_q <= err_code(state, idx);
      end else if (bus.err_clr) begin
        err_q       <= 1'b0;
        err_stage_q <= '0;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.ready) state <= ARM;
        end
        ARM: begin
          if (bus.trig) begin
            state  <= RUN;
            idx    <= '0;
            fs_q   <= onehot('0);
            busy_q <= 1'b1;
          end else if (!bus.ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (stage_done) begin
            fs_q <= '0;
            if (int'(idx) == REL_STAGE) begin
              state <= REL;
              ack_q <= 1'b1;
            end else if (int'(idx) == NSTAGE - 1) begin
              state <= DONE;
            end else begin
              idx  <= idx + 1'b1;
              fs_q <= onehot(idx + 1'b1);
            end
          end else if (tmo) begin
            state <= ERR;
            fs_q  <= '0;
            ack_q <= 1'b0;
          end
        end
        REL: begin
          if (rel_done) begin
            ack_q <= 1'b0;
            if (REL_STAGE == NSTAGE - 1) begin
              state <= DONE;
            end else begin
              state <= RUN;
              idx   <= IDX_W'(REL_STAGE + 1);
              fs_q  <= onehot(IDX_W'(REL_STAGE + 1));
            end
          end else if (tmo) begin
            state <= ERR;
            fs_q  <= '0;
            ack_q <= 1'b0;
          end
        end
        DONE: begin
          cnt_pkt_q <= cnt_pkt_q + 1'b1;
          state     <= IDLE;
          busy_q    <= 1'b0;
        end
        ERR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          fs_q   <= '0;
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fs        = fs_q;
  assign bus.ack_rx    = ack_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.err_stage = err_stage_q;
  assign bus.cnt_pkt   = cnt_pkt_q;
  assign bus.so        = state;

endmodule

// File: tb/tb_cmd_seq.sv
// Directed bench for cmd_seq with NSTAGE=3, REL_STAGE=0, TIMEOUT=16; the
// timeout scenarios run only when CMD_SEQ_TIMEOUT_EN is defined.
module tb_cmd_seq;

  logic sys_clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  cmd_seq_if #(.NSTAGE(3)) bus ();

  cmd_seq #(
    .NSTAGE    (3),
    .REL_STAGE (0),
    .TO_W      (16),
    .TIMEOUT   (16)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full pass with every fd pre-asserted: IDLE,ARM,RUN0,REL,RUN1,RUN2,DONE,IDLE.
  task automatic quick_seq();
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b111;
    step(2);
    bus.trig  = 1'b0;
    step(4);
    bus.ready = 1'b0;
    step(1);
    bus.fd    = 3'b000;
  endtask

  initial begin
    rst         = 1'b1;
    bus.ready   = 1'b0;
    bus.trig    = 1'b0;
    bus.fd      = 3'b000;
    bus.err_clr = 1'b0;
    step(2);
    chk("rst_fs",        32'(bus.fs),        32'h0);
    chk("rst_ack",       32'(bus.ack_rx),    32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_err",       32'(bus.err),       32'h0);
    chk("rst_err_stage", 32'(bus.err_stage), 32'h0);
    chk("rst_cnt",       32'(bus.cnt_pkt),   32'h0);
    chk("rst_so",        32'(bus.so),        32'h08);
    rst = 1'b0;
    step(1);

    // Main sequence with spaced fd pulses
    bus.ready = 1'b1;
    step(1);
    chk("arm_so", 32'(bus.so), 32'h03);
    bus.trig = 1'b1;
    step(1);
    chk("run0_fs",   32'(bus.fs),   32'h1);
    chk("run0_so",   32'(bus.so),   32'h09);
    chk("run0_busy", 32'(bus.busy), 32'h1);
    step(4);
    chk("run0_hold", 32'(bus.fs), 32'h1);
    bus.fd = 3'b001;
    step(1);
    chk("rel_fs",  32'(bus.fs),     32'h0);
    chk("rel_ack", 32'(bus.ack_rx), 32'h1);
    chk("rel_so",  32'(bus.so),     32'h0A);
    bus.fd = 3'b000;
    step(2);
    chk("rel_hold", 32'(bus.ack_rx), 32'h1);
    bus.trig = 1'b0;
    step(1);
    chk("run1_fs",  32'(bus.fs),     32'h2);
    chk("run1_ack", 32'(bus.ack_rx), 32'h0);
    bus.fd = 3'b101;
    step(1);
    chk("fd_other_ignored", 32'(bus.fs), 32'h2);
    bus.fd = 3'b000;
    step(1);
    bus.fd = 3'b010;
    step(1);
    chk("run2_fs", 32'(bus.fs), 32'h4);
    bus.fd = 3'b000;
    step(2);
    bus.fd = 3'b100;
    step(1);
    chk("done_fs",   32'(bus.fs),      32'h0);
    chk("done_so",   32'(bus.so),      32'h0B);
    chk("done_busy", 32'(bus.busy),    32'h1);
    chk("done_cnt",  32'(bus.cnt_pkt), 32'h0);
    bus.fd    = 3'b000;
    bus.ready = 1'b0;
    step(1);
    chk("idle_so",   32'(bus.so),      32'h08);
    chk("idle_busy", 32'(bus.busy),    32'h0);
    chk("idle_cnt",  32'(bus.cnt_pkt), 32'h1);

    // Not ready: trig must be ignored
    bus.trig = 1'b1;
    step(10);
    chk("nrdy_so", 32'(bus.so), 32'h08);
    chk("nrdy_fs", 32'(bus.fs), 32'h0);
    bus.trig  = 1'b0;
    bus.ready = 1'b1;
    step(1);
    chk("arm_again", 32'(bus.so), 32'h03);
    bus.ready = 1'b0;
    step(1);
    chk("arm_ready_drop", 32'(bus.so), 32'h08);

    // fd already high at stage entry: one cycle of fs per stage
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b111;
    step(2);
    chk("pre_run0", 32'(bus.fs), 32'h1);
    bus.trig = 1'b0;
    step(1);
    chk("pre_rel_ack", 32'(bus.ack_rx), 32'h1);
    chk("pre_rel_fs",  32'(bus.fs),     32'h0);
    step(1);
    chk("pre_run1",     32'(bus.fs),     32'h2);
    chk("pre_run1_ack", 32'(bus.ack_rx), 32'h0);
    step(1);
    chk("pre_run2", 32'(bus.fs), 32'h4);
    bus.ready = 1'b0;
    step(1);
    chk("pre_done", 32'(bus.so), 32'h0B);
    step(1);
    chk("pre_idle", 32'(bus.so),      32'h08);
    chk("pre_cnt",  32'(bus.cnt_pkt), 32'h2);
    bus.fd = 3'b000;

    // Asynchronous reset while stage 2 is active
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b011;
    step(2);
    bus.trig = 1'b0;
    step(3);
    chk("pre_rst_fs2", 32'(bus.fs), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst_fs",   32'(bus.fs),      32'h0);
    chk("arst_busy", 32'(bus.busy),    32'h0);
    chk("arst_so",   32'(bus.so),      32'h08);
    chk("arst_ack",  32'(bus.ack_rx),  32'h0);
    chk("arst_cnt",  32'(bus.cnt_pkt), 32'h0);
    bus.fd    = 3'b000;
    bus.ready = 1'b0;
    step(1);
    rst = 1'b0;
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    step(2);
    chk("post_rst_stage0", 32'(bus.fs), 32'h1);
    bus.fd   = 3'b111;
    bus.trig = 1'b0;
    step(3);
    bus.ready = 1'b0;
    step(2);
    bus.fd = 3'b000;
    chk("post_rst_cnt", 32'(bus.cnt_pkt), 32'h1);

    // Packet counter wrap
    force dut.cnt_pkt_q = 16'hFFFF;
    step(1);
    release dut.cnt_pkt_q;
    step(1);
    chk("cnt_preload", 32'(bus.cnt_pkt), 32'hFFFF);
    quick_seq();
    chk("cnt_wrap", 32'(bus.cnt_pkt), 32'h0);
    quick_seq();
    chk("cnt_after_wrap", 32'(bus.cnt_pkt), 32'h1);

`ifdef CMD_SEQ_TIMEOUT_EN
    // Stage 1 stalls: fs[1] high for 16 cycles, then ERR, then IDLE
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b001;
    step(2);
    bus.trig = 1'b0;
    step(2);
    bus.fd    = 3'b000;
    bus.ready = 1'b0;
    step(15);
    chk("to1_fs_hold", 32'(bus.fs),  32'h2);
    chk("to1_no_err",  32'(bus.err), 32'h0);
    step(1);
    chk("to1_fs",        32'(bus.fs),        32'h0);
    chk("to1_so",        32'(bus.so),        32'h0F);
    chk("to1_err",       32'(bus.err),       32'h1);
    chk("to1_err_stage", 32'(bus.err_stage), 32'h1);
    chk("to1_busy",      32'(bus.busy),      32'h1);
    step(1);
    chk("to1_idle",   32'(bus.so),      32'h08);
    chk("to1_cnt",    32'(bus.cnt_pkt), 32'h1);
    chk("to1_sticky", 32'(bus.err),     32'h1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    chk("clr_err",       32'(bus.err),       32'h0);
    chk("clr_err_stage", 32'(bus.err_stage), 32'h0);

    // fd arriving in the expiring cycle wins
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b001;
    step(2);
    bus.trig = 1'b0;
    step(2);
    bus.fd    = 3'b000;
    bus.ready = 1'b0;
    step(15);
    bus.fd = 3'b010;
    step(1);
    chk("race_fs",  32'(bus.fs),  32'h4);
    chk("race_err", 32'(bus.err), 32'h0);
    bus.fd = 3'b100;
    step(2);
    bus.fd = 3'b000;
    chk("race_cnt", 32'(bus.cnt_pkt), 32'h2);

    // Release step stalls with trig held; err_clr in the same cycle loses
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b001;
    step(3);
    chk("relto_entry", 32'(bus.ack_rx), 32'h1);
    bus.fd    = 3'b000;
    bus.ready = 1'b0;
    step(15);
    chk("relto_hold", 32'(bus.ack_rx), 32'h1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    chk("relto_ack",       32'(bus.ack_rx),    32'h0);
    chk("relto_so",        32'(bus.so),        32'h0F);
    chk("relto_err",       32'(bus.err),       32'h1);
    chk("relto_err_stage", 32'(bus.err_stage), 32'hF);
    bus.trig = 1'b0;
    step(1);
    chk("relto_idle", 32'(bus.so), 32'h08);
`else
    // Without the timeout option a stalled stage waits indefinitely
    bus.ready = 1'b1;
    bus.trig  = 1'b1;
    bus.fd    = 3'b001;
    step(2);
    bus.trig = 1'b0;
    step(2);
    bus.fd    = 3'b000;
    bus.ready = 1'b0;
    bus.err_clr = 1'b1;
    step(40);
    bus.err_clr = 1'b0;
    chk("stall_fs",  32'(bus.fs),  32'h2);
    chk("stall_err", 32'(bus.err), 32'h0);
    bus.fd = 3'b110;
    step(3);
    bus.fd = 3'b000;
    chk("stall_cnt", 32'(bus.cnt_pkt), 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
